// File: rtl/seven_seg_scan_ctrl.sv
// Eight-digit common-anode 7-segment scan controller.
// Digit codes are written into a shadow bank and copied to the active bank only
// at a frame boundary, so a displayed frame never mixes old and new contents.
// Each digit slot is a BLANK gap (all anodes off) followed by a DRIVE dwell.
module seven_seg_scan_ctrl #(
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [4:0] wr_data,
  input  logic       commit,
  input  logic [7:0] digit_mask,
  output logic       commit_pending,
  output logic       frame_start,
  output logic       CA,
  output logic       CB,
  output logic       CC,
  output logic       CD,
  output logic       CE,
  output logic       CF,
  output logic       CG,
  output logic       AN0,
  output logic       AN1,
  output logic       AN2,
  output logic       AN3,
  output logic       AN4,
  output logic       AN5,
  output logic       AN6,
  output logic       AN7
);

  localparam int unsigned MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  // Blank flag set, hex value don't-care: the power-up contents of both banks.
  localparam logic [4:0] BLANK_CODE = 5'h10;

  logic [0:0]       state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             slot_end;
  logic             frame_boundary;
  logic             copy_now;
  logic             pending_q, pending_d;
  logic             frame_start_q;
  logic [6:0]       seg_q, seg_d;
  logic [7:0]       an_q, an_d;
  logic [4:0]       active_bus [8];
  logic [4:0]       cur_code;
  logic             lit;

  // Segment pattern {CG,CF,CE,CD,CC,CB,CA}, active-low.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h7F;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Slot sequencer: one up-counter shared by both states, restarted on every slot change.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q + 1'b1;
    slot_end = (state_q == ST_BLANK) ? (cnt_q == BLANK_LAST) : (cnt_q == DWELL_LAST);
    if (slot_end) begin
      cnt_d = '0;
      if (state_q == ST_BLANK) begin
        state_d = ST_DRIVE;
      end else begin
        state_d = ST_BLANK;
        idx_d   = idx_q + 3'd1;
      end
    end
  end

  // The last DRIVE cycle of digit 7 is the only point where the banks may be swapped.
  assign frame_boundary = (state_q == ST_DRIVE) && (idx_q == 3'd7) && slot_end;
  assign copy_now       = frame_boundary && (pending_q || commit);
  assign pending_d      = copy_now ? 1'b0 : (pending_q || commit);

  // Sequencer, commit tracking and frame pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_BLANK;
      idx_q         <= 3'd0;
      cnt_q         <= '0;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_boundary;
    end
  end

  // Per-digit shadow/active storage; the copy reads shadow as it was before this edge.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_digit
      logic [4:0] shadow_q;
      logic [4:0] active_q;

      // Shadow takes host writes; active only ever loads from shadow at a boundary.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          shadow_q <= BLANK_CODE;
          active_q <= BLANK_CODE;
        end else begin
          if (wr_en && (wr_addr == 3'(gi))) shadow_q <= wr_data;
          if (copy_now) active_q <= shadow_q;
        end
      end

      assign active_bus[gi] = active_q;
    end
  endgenerate

  // Output pattern for the state being entered, so registered outputs line up with the state.
  always_comb begin
    cur_code = active_bus[idx_d];
    lit      = (state_d == ST_DRIVE) && digit_mask[idx_d] && !cur_code[4];
    seg_d    = lit ? seg_decode(cur_code[3:0]) : 7'h7F;
  end

  generate
    for (gi = 0; gi < 8; gi++) begin : g_anode
      assign an_d[gi] = !(lit && (idx_d == 3'(gi)));
    end
  endgenerate

  // Registered pin drivers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_q <= 7'h7F;
      an_q  <= 8'hFF;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign commit_pending = pending_q;
  assign frame_start    = frame_start_q;

  assign CA  = seg_q[0];
  assign CB  = seg_q[1];
  assign CC  = seg_q[2];
  assign CD  = seg_q[3];
  assign CE  = seg_q[4];
  assign CF  = seg_q[5];
  assign CG  = seg_q[6];
  assign AN0 = an_q[0];
  assign AN1 = an_q[1];
  assign AN2 = an_q[2];
  assign AN3 = an_q[3];
  assign AN4 = an_q[4];
  assign AN5 = an_q[5];
  assign AN6 = an_q[6];
  assign AN7 = an_q[7];

endmodule
